// File: rtl/display_buf_pkg.sv
// Shared definitions for the display output buffer: FIFO geometry,
// transmitter state encoding and the baud divider derivation.
package display_buf_pkg;

  localparam int FIFO_DEPTH = 32;
  localparam int PTR_W      = 6;
  localparam int ADDR_W     = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // Number of system clocks per serial bit; integer division, caller keeps it >= 2.
  function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/display_buf_uart_tx.sv
// 8N1 serial transmitter that pulls characters from the display FIFO.
// The pop strobe is combinational so the FIFO read pointer advances on the
// same edge that loads the shift register.
module uart_tx
  import display_buf_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] pop_data,
  input  logic       fifo_empty,
  output logic       pop,
  output logic       tx,
  output logic       tx_busy
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  tx_state_t        state;
  logic [CNT_W-1:0] baud_cnt;
  logic [7:0]       shift_reg;
  logic [2:0]       bit_idx;
  logic             bit_done;

  assign bit_done = (baud_cnt == CNT_LAST);

  // A character leaves the FIFO when idle, or at the very end of a stop bit
  // so back-to-back frames have no gap.
  assign pop = ~fifo_empty & ((state == IDLE) | ((state == STOP) & bit_done));

  // Frame sequencing: state, baud counter, shift register and busy flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      shift_reg <= '0;
      bit_idx   <= '0;
      tx_busy   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          bit_idx  <= '0;
          if (!fifo_empty) begin
            shift_reg <= {1'b0, pop_data};
            state     <= START;
            tx_busy   <= 1'b1;
          end
        end
        START: begin
          if (bit_done) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (bit_done) begin
            baud_cnt  <= '0;
            shift_reg <= {1'b0, shift_reg[7:1]};
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (bit_done) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            if (!fifo_empty) begin
              shift_reg <= {1'b0, pop_data};
              state     <= START;
            end else begin
              state   <= IDLE;
              tx_busy <= 1'b0;
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        default: begin
          state   <= IDLE;
          tx_busy <= 1'b0;
        end
      endcase
    end
  end

  // Registered line driver; forced high immediately by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx <= 1'b1;
    end else begin
      case (state)
        START:   tx <= 1'b0;
        DATA:    tx <= shift_reg[0];
        default: tx <= 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/display_buf.sv
// Display output buffer: 32-entry character FIFO written by the CPU and
// drained by the serial transmitter onto the UART TX pin.
module display_buf
  import display_buf_pkg::*;
#(
  parameter int baud_rate = 115200,
  parameter int clk_freq  = 100000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       DS_write_en,
  input  logic [6:0] write_data,
  input  logic       DS_clear,
  output logic       DS_status,
  output logic       buf_empty,
  output logic       tx_busy,
  output logic       tx
);

  localparam int CLKS_PER_BIT = clks_per_bit(clk_freq, baud_rate);

  logic [6:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [ADDR_W-1:0] read_addr;
  logic [6:0]        pop_data;
  logic              full;
  logic              empty;
  logic              write_ok;
  logic              pop;
  logic              tx_fifo_empty;

  // Extra pointer MSB distinguishes full from empty when the low bits match.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                    (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign write_ok = DS_write_en & ~full;

  assign read_addr = rd_ptr[ADDR_W-1:0];
  assign pop_data  = mem[read_addr];

  // A flush in progress hides the FIFO contents so nothing flushed gets sent.
  assign tx_fifo_empty = empty | DS_clear;

  assign DS_status = ~full;
  assign buf_empty = empty;

  // Character storage, written on accepted CPU writes only.
  always_ff @(posedge clk) begin
    if (write_ok) begin
      mem[wr_ptr[ADDR_W-1:0]] <= write_data;
    end
  end

  // Pointer update; a flush wins over any same-cycle write or pop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (DS_clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (write_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_tx (
    .clk       (clk),
    .reset_n   (reset_n),
    .pop_data  (pop_data),
    .fifo_empty(tx_fifo_empty),
    .pop       (pop),
    .tx        (tx),
    .tx_busy   (tx_busy)
  );

endmodule

// File: tb/tb_display_buf.sv
// Scoreboard bench for display_buf: accepted characters are queued when
// written, and a serial monitor pops and compares each frame on the line.
module tb_display_buf;

  localparam int CPB       = 16;
  localparam int FRAME_LEN = 10 * CPB;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       DS_write_en = 1'b0;
  logic [6:0] write_data = '0;
  logic       DS_clear = 1'b0;
  logic       DS_status;
  logic       buf_empty;
  logic       tx_busy;
  logic       tx;

  int tests_run = 0;
  int tests_failed = 0;
  int cycle_cnt = 0;

  logic [6:0] exp_q[$];
  logic       mon_en = 1'b0;
  logic       in_frame = 1'b0;
  int         gap_exp = 0;
  int         last_start = -1;

  logic [9:0] frame;
  logic [7:0] got;
  logic [6:0] exp_ch;
  logic       have_exp;
  int         bad;
  int         start_cyc;

  display_buf #(
    .baud_rate(1),
    .clk_freq (16)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .DS_write_en(DS_write_en),
    .write_data (write_data),
    .DS_clear   (DS_clear),
    .DS_status  (DS_status),
    .buf_empty  (buf_empty),
    .tx_busy    (tx_busy),
    .tx         (tx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyReset();
    @(negedge clk);
    reset_n     = 1'b0;
    DS_write_en = 1'b0;
    DS_clear    = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Drives one write at the next falling edge; expected characters are queued.
  task automatic applyStimulus(input logic [6:0] ch, input bit accepted);
    @(negedge clk);
    DS_write_en = 1'b1;
    write_data  = ch;
    if (accepted) exp_q.push_back(ch);
  endtask

  task automatic endWrite();
    @(negedge clk);
    DS_write_en = 1'b0;
  endtask

  task automatic waitDrain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || in_frame || tx_busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain_timeout", int'(n >= budget), 0);
  endtask

  // Serial monitor: checks every cycle of each frame against the expected character.
  always begin
    @(negedge clk);
    if (mon_en && tx === 1'b0) begin
      in_frame  = 1'b1;
      start_cyc = cycle_cnt;
      if (gap_exp != 0 && last_start >= 0) checkOutput("frame_gap", start_cyc - last_start, gap_exp);
      last_start = start_cyc;
      have_exp = (exp_q.size() > 0);
      exp_ch   = have_exp ? exp_q.pop_front() : 7'h00;
      if (!have_exp) checkOutput("unexpected_frame", 1, 0);
      frame = {1'b1, 1'b0, exp_ch, 1'b0};
      bad   = 0;
      got   = '0;
      for (int i = 0; i < FRAME_LEN; i++) begin
        if (i > 0) @(negedge clk);
        if (tx !== frame[i / CPB]) bad++;
        if ((i % CPB) == CPB / 2 && (i / CPB) >= 1 && (i / CPB) <= 8) got[(i / CPB) - 1] = tx;
      end
      if (have_exp) begin
        checkOutput("frame_char", got, {1'b0, exp_ch});
        checkOutput("frame_shape", bad, 0);
      end
      in_frame = 1'b0;
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL global_timeout: got timeout, expected completion");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
    $fatal(1, "[TB] simulation timed out");
  end

  initial begin
    int lows;

    // Reset values and mid-frame reset abort
    applyReset();
    @(negedge clk);
    checkOutput("rst_tx", tx, 1);
    checkOutput("rst_status", DS_status, 1);
    checkOutput("rst_empty", buf_empty, 1);
    checkOutput("rst_busy", tx_busy, 0);
    applyStimulus(7'h41, 0);
    endWrite();
    repeat (50) @(negedge clk);
    checkOutput("midframe_tx_low", tx, 0);
    reset_n = 1'b0;
    #1;
    checkOutput("async_rst_tx", tx, 1);
    checkOutput("async_rst_busy", tx_busy, 0);
    checkOutput("async_rst_empty", buf_empty, 1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    lows = 0;
    repeat (200) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_busy !== 1'b0) lows++;
    end
    checkOutput("no_frame_after_reset", lows, 0);

    // Single character 0x41
    mon_en = 1'b1;
    applyReset();
    gap_exp = 0;
    applyStimulus(7'h41, 1);
    endWrite();
    checkOutput("single_empty_after_write", buf_empty, 0);
    checkOutput("single_busy_before_pop", tx_busy, 0);
    @(negedge clk);
    checkOutput("single_empty_after_pop", buf_empty, 1);
    checkOutput("single_busy_after_pop", tx_busy, 1);
    checkOutput("single_tx_still_high", tx, 1);
    repeat (159) @(negedge clk);
    checkOutput("single_busy_last", tx_busy, 1);
    @(negedge clk);
    checkOutput("single_busy_done", tx_busy, 0);
    waitDrain(400);

    // 34 consecutive writes: fill, overflow drop, back-to-back frames
    applyReset();
    gap_exp = FRAME_LEN;
    last_start = -1;
    for (int i = 0; i < 34; i++) begin
      applyStimulus(7'(8'h30 + i), i < 33);
      if (i == 32) checkOutput("fill_status_31", DS_status, 1);
      if (i == 33) checkOutput("fill_status_full", DS_status, 0);
    end
    endWrite();
    checkOutput("overflow_status", DS_status, 0);
    checkOutput("overflow_not_empty", buf_empty, 0);
    waitDrain(34 * FRAME_LEN + 400);
    checkOutput("fill_drained_empty", buf_empty, 1);
    checkOutput("fill_drained_status", DS_status, 1);

    // Flush during first frame
    applyReset();
    gap_exp = 0;
    for (int i = 0; i < 5; i++) applyStimulus(7'(8'h61 + i), i == 0);
    endWrite();
    repeat (35) @(negedge clk);
    DS_clear = 1'b1;
    @(negedge clk);
    DS_clear = 1'b0;
    checkOutput("clear_empty", buf_empty, 1);
    checkOutput("clear_frame_continues", tx_busy, 1);
    waitDrain(400);
    repeat (50) @(negedge clk);
    checkOutput("clear_idle_busy", tx_busy, 0);
    checkOutput("clear_idle_tx", tx, 1);
    checkOutput("clear_idle_empty", buf_empty, 1);

    // Write during the last stop-bit cycle with an empty FIFO
    applyReset();
    gap_exp = FRAME_LEN + 1;
    last_start = -1;
    applyStimulus(7'h55, 1);
    endWrite();
    repeat (159) @(negedge clk);
    applyStimulus(7'h56, 1);
    checkOutput("laststop_busy", tx_busy, 1);
    checkOutput("laststop_empty", buf_empty, 1);
    endWrite();
    checkOutput("laststop_idle", tx_busy, 0);
    checkOutput("laststop_stored", buf_empty, 0);
    @(negedge clk);
    checkOutput("laststop_restart", tx_busy, 1);
    checkOutput("laststop_popped", buf_empty, 1);
    waitDrain(2 * FRAME_LEN + 400);

    // Write while full on the same cycle as a pop
    applyReset();
    gap_exp = FRAME_LEN;
    last_start = -1;
    for (int i = 0; i < 33; i++) applyStimulus(7'(8'h40 + i), 1);
    endWrite();
    checkOutput("fullpop_full", DS_status, 0);
    repeat (127) @(negedge clk);
    applyStimulus(7'h7E, 0);
    checkOutput("fullpop_full_at_pop", DS_status, 0);
    applyStimulus(7'h7D, 1);
    checkOutput("fullpop_after_pop", DS_status, 1);
    endWrite();
    checkOutput("fullpop_refull", DS_status, 0);
    waitDrain(35 * FRAME_LEN + 400);

    // Pointer wrap over three batches
    applyReset();
    gap_exp = FRAME_LEN;
    for (int b = 0; b < 3; b++) begin
      last_start = -1;
      for (int i = 0; i < 20; i++) applyStimulus(7'(8'h20 + b * 20 + i), 1);
      endWrite();
      checkOutput("wrap_batch_not_empty", buf_empty, 0);
      checkOutput("wrap_batch_status", DS_status, 1);
      waitDrain(21 * FRAME_LEN + 400);
      checkOutput("wrap_drained_empty", buf_empty, 1);
      checkOutput("wrap_drained_status", DS_status, 1);
    end

    checkOutput("queue_leftover", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/display_buf.md
# display_buf

Output-side terminal buffer: the CPU enqueues 7-bit ASCII characters into a 32-entry FIFO, and an integrated UART transmitter drains them onto the serial line as 8N1 frames. It is the transmit counterpart of the keyboard input buffer. It sits between the CPU's display I/O register and the board UART TX pin.

## Interface
- `baud_rate`, 115200, serial bit rate.
- `clk_freq`, 100000000, clk frequency in Hz; `CLKS_PER_BIT = clk_freq / baud_rate` (integer division, must be ≥ 2).
- `clk`  in  1  system clock, all state on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `DS_write_en`  in  1  enqueue `write_data` this cycle.
- `write_data`  in  7  ASCII character.
- `DS_clear`  in  1  synchronous FIFO flush.
- `DS_status`  out  1  1 = FIFO not full, CPU may write.
- `buf_empty`  out  1  1 = FIFO holds no characters.
- `tx_busy`  out  1  1 = frame in progress.
- `tx`  out  1  serial line, idle high, registered.

## Operation
- FIFO: 32 x 7 bits. Write and read pointers are 6 bits each.
  - Empty when the pointers are fully equal.
  - Full when the MSBs differ and the low 5 bits are equal.
  - Pointers wrap naturally mod 64.
- Write accepted when `DS_write_en & ~full`. A write while full is silently dropped, with no pointer change.
- `DS_clear` zeroes both pointers at the next edge. It has priority over a same-cycle write or pop. A frame already in progress completes unchanged.
- Transmitter FSM states: IDLE, START, DATA, STOP.
  - IDLE: if FIFO non-empty, pop the head into the 8-bit shift register `{1'b0, char}` and go to START. Otherwise stay, with `tx = 1`.
  - START: `tx = 0` for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: 8 bits LSB first, CLKS_PER_BIT cycles each. Bit 7 is always 0. After bit 7, go to STOP.
  - STOP: `tx = 1` for CLKS_PER_BIT cycles. On its last cycle:
    - if FIFO non-empty (and no `DS_clear`), pop and go directly to START;
    - otherwise go to IDLE.
- Baud counter runs from 0 to CLKS_PER_BIT-1 and resets on every state change.
- Pop and write in the same cycle are both honoured.
  - Full + pop: the write is still dropped, because full is evaluated before the pop.
  - Empty + write: the pop does not occur; the character is popped next cycle.
- `tx_busy = (state != IDLE)`.

## Timing
- Reset values: `tx = 1`, `DS_status = 1`, `buf_empty = 1`, `tx_busy = 0`. FSM in IDLE, pointers 0, baud counter 0.
- Assertion of `reset_n` mid-frame aborts the frame immediately; `tx` goes to 1 asynchronously.
- Status flags are combinational from the pointers, so they update in the cycle after the causing edge.
- First-character latency from IDLE:
  - write at edge k;
  - pop at edge k+1;
  - `tx` low from edge k+2 (registered output);
  - `tx_busy` high from edge k+1.
- Frame length is exactly 10·CLKS_PER_BIT cycles. Back-to-back frames have no idle gap.
- `DS_status` falls after the edge of the write that fills the FIFO. It rises after the edge of the next pop.

## Structure
- Shared package holds:
  - FIFO depth (32) and pointer width (6);
  - FSM state encoding (IDLE/START/DATA/STOP, 2 bits);
  - the CLKS_PER_BIT derivation.
- One sub-module, `uart_tx`, contains the FSM, baud counter and shift register.
  - Inputs: `pop_data[6:0]`, `fifo_empty`.
  - Outputs: `pop`, `tx`, `tx_busy`.
- FIFO storage and pointers live in `display_buf`. Storage reads asynchronously at `read_addr[4:0]`.

## Test plan
All scenarios use `clk_freq = 16`, `baud_rate = 1`, giving CLKS_PER_BIT = 16.
1. Reset → `tx = 1`, `DS_status = 1`, `buf_empty = 1`, `tx_busy = 0`. Assert `reset_n` mid-frame → `tx = 1` with no clock edge, and no further frames.
2. Single write 0x41 → `tx` low 16 cycles, then bits 1,0,0,0,0,0,1,0 at 16 cycles each, then high 16 cycles. `buf_empty = 1` after the pop edge; `tx_busy = 0` after 160 cycles.
3. 34 consecutive writes of 0x30..0x51:
   - first popped immediately, next 32 stored;
   - `DS_status = 0` after the 33rd write, and the 34th (0x51) is dropped;
   - line carries 0x30..0x50 in order with frames exactly 160 cycles apart.
4. Five writes, then `DS_clear` 40 cycles into the first frame → first frame completes intact, `tx` then stays high, `buf_empty = 1`, `tx_busy = 0`.
5. Write during the last STOP cycle with an empty FIFO → next START begins within 2 cycles. Write with the FIFO full on the same cycle as a pop → dropped, and the pointer count is unchanged.
6. Pointer wrap: 3 batches of 20 writes (0x20..0x5B), each drained fully → 60 characters out in order; `buf_empty`/`DS_status` correct across the 32/64 pointer wrap.
